alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Sequencer that shares one 64-bit ALU (A, B, 3-bit cntrl; result plus negative/zero/overflow/carry_out flags) between two requesters.
- Arbitrates round-robin and latches the winning operation into registers that drive the ALU.
- Holds the ALU inputs stable for a programmable settle time so the gate-delay ALU can resolve, then captures the result and flags into a response register.
- Maintains the architectural NZVC flag register for flag-setting operations.

Parameters:
- WIDTH, 64, operand/result width.
- SETTLE_CYCLES, 2, cycles the ALU inputs are held before sampling; must be ≥1 (0 is illegal).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  WIDTH  operands.
- req0_cntrl  in  3  ALU op code.
- req0_setflags  in  1  update NZVC when this op completes.
- req1_valid, req1_ready, req1_a, req1_b, req1_cntrl, req1_setflags: same as requester 0.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes response.
- rsp_id  out  1  requester that issued the op.
- rsp_result  out  WIDTH  captured ALU result.
- rsp_nzvc  out  4  captured {negative, zero, overflow, carry_out}.
- alu_a, alu_b  out  WIDTH  registered ALU operands.
- alu_cntrl  out  3  registered ALU op code.
- alu_result  in  WIDTH  ALU result.
- alu_negative, alu_zero, alu_overflow, alu_carry_out  in  1 each  ALU flags.
- flags_nzvc  out  4  architectural flag register.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE.
  - alu_a=alu_b=0, alu_cntrl=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_nzvc=0.
  - flags_nzvc=0.
  - last_grant=1, so req0 wins the first tie.
  - req0_ready=req1_ready=0 and busy=0 while reset is low.
  - An in-flight op is discarded with no response.
- States:
  - IDLE: accepting.
  - EXEC: ALU settling.
  - RESP: holding response.
- IDLE grant (combinational):
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - reqX_ready = (state==IDLE) && reqX_valid && grant==X. At most one ready is high per cycle.
- Accept edge (valid && ready):
  - Latch a/b/cntrl into alu_a/alu_b/alu_cntrl; latch id and setflags.
  - cnt <= SETTLE_CYCLES-1; state -> EXEC.
- EXEC:
  - ALU inputs constant; both readys low.
  - At each edge: if cnt != 0, decrement. If cnt == 0:
    - rsp_result <= alu_result; rsp_nzvc <= flags; rsp_id <= latched id.
    - rsp_valid <= 1; last_grant <= id; state -> RESP.
    - If setflags=1, flags_nzvc <= {alu_negative, alu_zero, alu_overflow, alu_carry_out} on the same edge; otherwise flags_nzvc is unchanged.
- Latency: accept at edge E0 → rsp_valid high after edge E0+SETTLE_CYCLES. ALU inputs are stable for exactly SETTLE_CYCLES cycles before sampling.
- RESP:
  - rsp_* and alu_* held stable until rsp_valid && rsp_ready; at that edge rsp_valid <= 0 and state -> IDLE.
  - No new accept in the same cycle; earliest next accept is the following cycle.
  - Minimum issue interval is SETTLE_CYCLES+2 cycles.
- Requester protocol:
  - Once valid is asserted, operands stay stable until ready.
  - Dropping valid before ready is permitted and has no effect.
  - A non-granted valid requester waits; it is never starved, because a tie always alternates.
- cntrl is passed through unmodified; the arbiter does not decode op codes. ALU codes: 000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor.
- alu_* outputs retain the last op's values after return to IDLE.

Test Plan:
1. SETTLE_CYCLES=2, req0 A=5, B=7, cntrl=010, setflags=1, rsp_ready=1 → req0_ready for 1 cycle; rsp_valid rises 2 edges after accept; rsp_result=12, rsp_id=0, rsp_nzvc=0000, flags_nzvc=0000; busy drops the cycle after handshake.
2. req1 A=3, B=3, cntrl=011, setflags=1 → result 0, rsp_nzvc=0101, flags_nzvc=0101. Then req1 A=0, B=1, cntrl=011, setflags=0 → result 0xFFFF_FFFF_FFFF_FFFF, rsp_nzvc=1000, flags_nzvc stays 0101.
3. req0 A=0x7FFF_FFFF_FFFF_FFFF, B=1, cntrl=010, setflags=1 → result 0x8000_0000_0000_0000, flags_nzvc=1010.
4. Both requesters held valid continuously for 4 ops after reset → grant order 0,1,0,1; rsp_id matches the order; the waiting requester's ready stays low while busy.
5. rsp_ready held low 5 cycles in RESP → rsp_valid, rsp_result, alu_a/alu_b/alu_cntrl stable and both readys low throughout; after rsp_ready=1, IDLE on the next edge and a pending request accepted the cycle after.
6. reset driven low one cycle into EXEC of a setflags op → all outputs immediately at reset values; after release no response appears for that op; flags_nzvc=0000; the next tie grants req0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational 64-bit ALU between two
// requesters. A round-robin winner's operation is registered onto the ALU
// inputs, held for SETTLE_CYCLES cycles so the gate-level ALU resolves, then
// the result and flags are captured into a response register. The
// architectural NZVC register is updated by ops that request it.
module alu_arbiter #(
    parameter int WIDTH         = 64,
    parameter int SETTLE_CYCLES = 2     // must be >= 1
) (
    input  logic             clk,
    input  logic             reset,          // asynchronous, active-low

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_cntrl,
    input  logic             req0_setflags,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_cntrl,
    input  logic             req1_setflags,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_nzvc,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_cntrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_negative,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry_out,

    output logic [3:0]       flags_nzvc,
    output logic             busy
);

    // Settle counter is loaded with SETTLE_CYCLES-1; keep at least one bit.
    localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             last_grant_reg;
    logic             id_reg;
    logic             setflags_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             grant;
    logic             accept;
    logic             capture;
    logic             release_rsp;

    // Round-robin choice: a lone requester wins; on a tie the one that was
    // not served last wins, so neither side can starve.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_reg;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Readies are forced low while reset is asserted, even though the state
    // register already reads IDLE during reset.
    assign req0_ready = reset && (state_reg == IDLE) && req0_valid && !grant;
    assign req1_ready = reset && (state_reg == IDLE) && req1_valid &&  grant;
    assign busy       = (state_reg != IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        capture     = 1'b0;
        release_rsp = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (cnt_reg == '0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    release_rsp = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operation latch: ALU inputs are loaded only on accept and otherwise
    // hold, so they stay stable through EXEC/RESP and keep the last op in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_cntrl    <= '0;
            id_reg       <= 1'b0;
            setflags_reg <= 1'b0;
        end else if (accept) begin
            alu_a        <= grant ? req1_a        : req0_a;
            alu_b        <= grant ? req1_b        : req0_b;
            alu_cntrl    <= grant ? req1_cntrl    : req0_cntrl;
            id_reg       <= grant;
            setflags_reg <= grant ? req1_setflags : req0_setflags;
        end
    end

    // Settle counter: loaded on accept, counts down while the ALU resolves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (accept) begin
            cnt_reg <= CNT_LOAD;
        end else if ((state_reg == EXEC) && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    // Response register and round-robin history, written when the ALU output
    // is sampled; the response is dropped once the consumer takes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid      <= 1'b0;
            rsp_id         <= 1'b0;
            rsp_result     <= '0;
            rsp_nzvc       <= '0;
            last_grant_reg <= 1'b1;
        end else if (capture) begin
            rsp_valid      <= 1'b1;
            rsp_id         <= id_reg;
            rsp_result     <= alu_result;
            rsp_nzvc       <= {alu_negative, alu_zero, alu_overflow, alu_carry_out};
            last_grant_reg <= id_reg;
        end else if (release_rsp) begin
            rsp_valid      <= 1'b0;
        end
    end

    // Architectural NZVC: only flag-setting ops update it, on the sample edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_nzvc <= '0;
        end else if (capture && setflags_reg) begin
            flags_nzvc <= {alu_negative, alu_zero, alu_overflow, alu_carry_out};
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a behavioural ALU closes the loop, directed
// operations carry hand-computed expectations into a scoreboard queue, and a
// monitor compares every taken response against the queue head.
module tb_alu_arbiter;

    localparam int W      = 64;
    localparam int SETTLE = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready, req0_setflags;
    logic [W-1:0] req0_a, req0_b;
    logic [2:0]   req0_cntrl;
    logic         req1_valid, req1_ready, req1_setflags;
    logic [W-1:0] req1_a, req1_b;
    logic [2:0]   req1_cntrl;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_result;
    logic [3:0]   rsp_nzvc;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_cntrl;
    logic         alu_negative, alu_zero, alu_overflow, alu_carry_out;
    logic [3:0]   flags_nzvc;
    logic         busy;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_cntrl(req0_cntrl), .req0_setflags(req0_setflags),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_cntrl(req1_cntrl), .req1_setflags(req1_setflags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_nzvc(rsp_nzvc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl), .alu_result(alu_result),
        .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_carry_out(alu_carry_out),
        .flags_nzvc(flags_nzvc), .busy(busy)
    );

    // Behavioural ALU driven by the arbiter's registered operands.
    logic [W:0] sum;
    always_comb begin
        sum           = '0;
        alu_result    = '0;
        alu_overflow  = 1'b0;
        alu_carry_out = 1'b0;
        case (alu_cntrl)
            3'b000: alu_result = alu_b;
            3'b010: begin
                sum           = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result    = sum[W-1:0];
                alu_carry_out = sum[W];
                alu_overflow  = (alu_a[W-1] == alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
            end
            3'b011: begin
                sum           = {1'b0, alu_a} + {1'b0, ~alu_b} + 65'd1;
                alu_result    = sum[W-1:0];
                alu_carry_out = sum[W];
                alu_overflow  = (alu_a[W-1] != alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
            end
            3'b100: alu_result = alu_a & alu_b;
            3'b101: alu_result = alu_a | alu_b;
            3'b110: alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
        alu_negative = alu_result[W-1];
        alu_zero     = (alu_result == '0);
    end

    typedef struct {
        logic         id;
        logic [W-1:0] result;
        logic [3:0]   nzvc;
        logic [3:0]   flags;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic id, input logic [W-1:0] res, input logic [3:0] nzvc,
                            input logic [3:0] flags);
        exp_t e;
        e.id = id; e.result = res; e.nzvc = nzvc; e.flags = flags;
        sb.push_back(e);
    endtask

    // Monitor: every response the consumer takes is checked against the queue.
    always @(negedge clk) begin
        if (reset === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual id=%0d result=%h required no response",
                         rsp_id, rsp_result);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_id", W'(rsp_id), W'(mon_e.id));
                chk("rsp_result", rsp_result, mon_e.result);
                chk("rsp_nzvc", W'(rsp_nzvc), W'(mon_e.nzvc));
                chk("flags_nzvc", W'(flags_nzvc), W'(mon_e.flags));
                $display("rsp id=%0d result=%h nzvc=%b flags=%b", rsp_id, rsp_result,
                         rsp_nzvc, flags_nzvc);
            end
        end
    end

    task automatic set_req(input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] c, input logic sf, input logic v);
        if (who) begin
            req1_a = a; req1_b = b; req1_cntrl = c; req1_setflags = sf; req1_valid = v;
        end else begin
            req0_a = a; req0_b = b; req0_cntrl = c; req0_setflags = sf; req0_valid = v;
        end
    endtask

    // Wait (bounded) for the given requester's ready, then step past the accept edge.
    task automatic wait_ready(input bit who, input string tag);
        bit got = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if ((who ? req1_ready : req0_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_ready_timeout actual=0 required=1", tag);
        end else begin
            chk({tag, "_other_ready"}, W'(who ? req0_ready : req1_ready), '0);
        end
        @(posedge clk); #1;
    endtask

    // One op on an otherwise idle arbiter with rsp_ready high: checks the
    // one-cycle ready pulse, the response latency and the return to IDLE.
    task automatic issue_single(input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [2:0] c, input logic sf, input logic [W-1:0] er,
                                input logic [3:0] en, input logic [3:0] ef, input string tag);
        int  n;
        bit  got;
        push_exp(who, er, en, ef);
        set_req(who, a, b, c, sf, 1'b1);
        wait_ready(who, tag);
        chk({tag, "_ready_pulse"}, W'(who ? req1_ready : req0_ready), '0);
        if (who) req1_valid = 1'b0; else req0_valid = 1'b0;
        n = 0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n++;
            if (rsp_valid === 1'b1) begin got = 1'b1; break; end
        end
        chk({tag, "_latency"}, W'(got ? n : -1), W'(SETTLE));
        @(posedge clk); #1;
        chk({tag, "_busy_after"}, W'(busy), '0);
        chk({tag, "_rsp_valid_after"}, W'(rsp_valid), '0);
        $display("op %s id=%0d a=%h b=%h cntrl=%b sf=%0d latency=%0d", tag, who, a, b, c, sf, n);
    endtask

    logic [W-1:0] q0_a [4];
    logic [W-1:0] q0_b [4];
    logic [2:0]   q0_c [4];
    logic         q0_s [4];
    logic [W-1:0] q_r  [4];
    logic [3:0]   q_n  [4];
    logic [3:0]   q_f  [4];

    initial begin
        bit got;
        bit who;

        reset = 1'b0; rsp_ready = 1'b1;
        set_req(1'b0, '0, '0, 3'b000, 1'b0, 1'b1);
        set_req(1'b1, '0, '0, 3'b000, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready0", W'(req0_ready), '0);
        chk("rst_ready1", W'(req1_ready), '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_rsp_valid", W'(rsp_valid), '0);
        chk("rst_alu_a", alu_a, '0);
        chk("rst_flags", W'(flags_nzvc), '0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;

        // Single ops: add, sub to zero, sub with borrow (no flag update), signed overflow.
        issue_single(1'b0, 64'd5, 64'd7, 3'b010, 1'b1, 64'd12, 4'b0000, 4'b0000, "add5_7");
        issue_single(1'b1, 64'd3, 64'd3, 3'b011, 1'b1, 64'd0, 4'b0101, 4'b0101, "sub3_3");
        issue_single(1'b1, 64'd0, 64'd1, 3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000,
                     4'b0101, "sub0_1");
        issue_single(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b1,
                     64'h8000_0000_0000_0000, 4'b1010, 4'b1010, "add_ovf");

        // Response back-pressure with a second request pending.
        rsp_ready = 1'b0;
        push_exp(1'b0, 64'd3, 4'b0000, 4'b1010);
        set_req(1'b0, 64'd1, 64'd2, 3'b101, 1'b0, 1'b1);
        wait_ready(1'b0, "bp_or");
        req0_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid === 1'b1) begin got = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("bp_rsp_seen", W'(got), W'(1));
        push_exp(1'b1, 64'd2, 4'b0001, 4'b0001);
        set_req(1'b1, 64'd5, 64'd3, 3'b011, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", W'(rsp_valid), W'(1));
            chk("bp_rsp_result", rsp_result, 64'd3);
            chk("bp_alu_a", alu_a, 64'd1);
            chk("bp_alu_b", alu_b, 64'd2);
            chk("bp_alu_cntrl", W'(alu_cntrl), W'(3'b101));
            chk("bp_ready0", W'(req0_ready), '0);
            chk("bp_ready1", W'(req1_ready), '0);
        end
        $display("op bp_or held response for 5 cycles");
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_after", W'(busy), '0);
        chk("bp_pending_ready", W'(req1_ready), W'(1));
        @(posedge clk); #1;
        chk("bp_pending_accepted", W'(busy), W'(1));
        req1_valid = 1'b0;
        for (int i = 0; i < 20 && busy; i++) begin
            @(posedge clk); #1;
        end
        chk("bp_done", W'(busy), '0);
        $display("op bp_sub id=1 accepted the cycle after release");

        // Reset during EXEC of a flag-setting op discards it.
        set_req(1'b0, 64'd3, 64'd3, 3'b011, 1'b1, 1'b1);
        wait_ready(1'b0, "rst_exec");
        @(posedge clk); #1;
        req1_valid = 1'b1;
        reset = 1'b0;
        #1;
        chk("rx_busy", W'(busy), '0);
        chk("rx_ready0", W'(req0_ready), '0);
        chk("rx_ready1", W'(req1_ready), '0);
        chk("rx_rsp_valid", W'(rsp_valid), '0);
        chk("rx_rsp_result", rsp_result, '0);
        chk("rx_rsp_id", W'(rsp_id), '0);
        chk("rx_rsp_nzvc", W'(rsp_nzvc), '0);
        chk("rx_alu_a", alu_a, '0);
        chk("rx_alu_b", alu_b, '0);
        chk("rx_alu_cntrl", W'(alu_cntrl), '0);
        chk("rx_flags", W'(flags_nzvc), '0);
        $display("op rst_exec discarded by reset");

        // Tie stream: both requesters valid for four ops, grants must alternate from req0.
        q0_a[0] = 64'd10;     q0_b[0] = 64'd20;     q0_c[0] = 3'b010; q0_s[0] = 1'b1;
        q0_a[1] = 64'hFF;     q0_b[1] = 64'h0F;     q0_c[1] = 3'b110; q0_s[1] = 1'b0;
        q0_a[2] = 64'hF0F0;   q0_b[2] = 64'hFF00;   q0_c[2] = 3'b100; q0_s[2] = 1'b0;
        q0_a[3] = 64'h1234;   q0_b[3] = 64'd0;      q0_c[3] = 3'b000; q0_s[3] = 1'b1;
        q_r[0] = 64'd30;   q_n[0] = 4'b0000; q_f[0] = 4'b0000;
        q_r[1] = 64'hF0;   q_n[1] = 4'b0000; q_f[1] = 4'b0000;
        q_r[2] = 64'hF000; q_n[2] = 4'b0000; q_f[2] = 4'b0000;
        q_r[3] = 64'd0;    q_n[3] = 4'b0100; q_f[3] = 4'b0100;
        set_req(1'b0, q0_a[0], q0_b[0], q0_c[0], q0_s[0], 1'b1);
        set_req(1'b1, q0_a[1], q0_b[1], q0_c[1], q0_s[1], 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int n = 0; n < 50; n++) begin
                if (req0_ready === 1'b1 || req1_ready === 1'b1) begin got = 1'b1; break; end
                @(negedge clk);
            end
            chk("tie_grant_seen", W'(got), W'(1));
            who = (req1_ready === 1'b1);
            chk("tie_grant_order", W'(who), W'(k % 2));
            chk("tie_one_ready", W'(req0_ready && req1_ready), '0);
            push_exp(who, q_r[k], q_n[k], q_f[k]);
            $display("op tie k=%0d granted id=%0d", k, who);
            @(posedge clk); #1;
            if (k < 2) set_req(who, q0_a[k + 2], q0_b[k + 2], q0_c[k + 2], q0_s[k + 2], 1'b1);
            else if (who) req1_valid = 1'b0;
            else req0_valid = 1'b0;
            for (int n = 0; n < 50; n++) begin
                @(negedge clk);
                if (!busy) break;
                chk("tie_wait_ready0", W'(req0_ready), '0);
                chk("tie_wait_ready1", W'(req1_ready), '0);
            end
        end

        for (int i = 0; i < 50 && (sb.size() != 0 || busy); i++) @(posedge clk);
        #1;
        chk("scoreboard_drained", W'(sb.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
